// File: rtl/ex_muldiv_pkg.sv
// Shared mul/div encodings: md_op field values and engine state,
// used by the EX-stage engine and the hazard unit.
package ex_muldiv_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FIXUP = 2'd2
    } md_state_e;

    function automatic logic md_is_iter(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/ex_muldiv_datapath.sv
// Mul/div step logic: operand magnitudes, one shift-add or restoring
// divide step per call, and the final sign fixup into HI/LO values.
module ex_muldiv_datapath #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   data_1,
    input  logic [DATA_WIDTH-1:0]   data_2,
    input  logic                    signed_op,
    output logic [DATA_WIDTH-1:0]   mag_1,
    output logic [DATA_WIDTH-1:0]   mag_2,
    output logic                    sign_1,
    output logic                    sign_2,
    input  logic [2*DATA_WIDTH-1:0] acc,
    input  logic [DATA_WIDTH-1:0]   divisor,
    input  logic                    is_div,
    input  logic                    neg_q,
    input  logic                    neg_r,
    input  logic                    div_zero,
    input  logic [DATA_WIDTH-1:0]   rs,
    output logic [2*DATA_WIDTH-1:0] acc_next,
    output logic [DATA_WIDTH-1:0]   res_hi,
    output logic [DATA_WIDTH-1:0]   res_lo
);

    localparam int W = DATA_WIDTH;

    logic [W:0]     mul_sum;
    logic [W:0]     div_shift;
    logic [W:0]     div_diff;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   q_fix;
    logic [W-1:0]   r_fix;

    assign sign_1 = signed_op & data_1[W-1];
    assign sign_2 = signed_op & data_2[W-1];
    assign mag_1  = sign_1 ? -data_1 : data_1;
    assign mag_2  = sign_2 ? -data_2 : data_2;

    // acc = {upper, lower}: product halves for mul, {remainder, dividend/quotient} for div.
    // The shifted remainder stays below 2*divisor, so bit W of the difference is the borrow.
    always_comb begin
        mul_sum   = {1'b0, acc[2*W-1:W]} + ({1'b0, divisor} & {(W+1){acc[0]}});
        div_shift = {acc[2*W-1:W], acc[W-1]};
        div_diff  = div_shift - {1'b0, divisor};
        if (is_div) begin
            if (div_diff[W])
                acc_next = {div_shift[W-1:0], acc[W-2:0], 1'b0};
            else
                acc_next = {div_diff[W-1:0], acc[W-2:0], 1'b1};
        end else begin
            acc_next = {mul_sum, acc[W-1:1]};
        end
    end

    always_comb begin
        prod_fix = neg_q ? -acc : acc;
        q_fix    = neg_q ? -acc[W-1:0] : acc[W-1:0];
        r_fix    = neg_r ? -acc[2*W-1:W] : acc[2*W-1:W];
        if (!is_div) begin
            res_hi = prod_fix[2*W-1:W];
            res_lo = prod_fix[W-1:0];
        end else if (div_zero) begin
            res_hi = rs;
            res_lo = '1;
        end else begin
            res_hi = r_fix;
            res_lo = q_fix;
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide engine owning HI/LO; busy stalls
// the hazard unit for DATA_WIDTH+1 cycles per mul/div operation.
module ex_muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic                  i_flush,
    input  logic [2:0]            i_md_op,
    input  logic [DATA_WIDTH-1:0] i_data_1,
    input  logic [DATA_WIDTH-1:0] i_data_2,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_hi,
    output logic [DATA_WIDTH-1:0] o_lo
);

    import ex_muldiv_pkg::*;

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    md_state_e      state, state_nx;
    logic [CW-1:0]  cnt;
    logic [2*W-1:0] acc, acc_next;
    logic [W-1:0]   divisor, rs;
    logic           div_q, neg_q, neg_r, dz_q;
    logic [W-1:0]   mag_1, mag_2, res_hi, res_lo;
    logic           sign_1, sign_2;
    logic           accept, signed_op, is_div_op;
    logic           load, step, write_res, write_hi, write_lo;

    assign accept = (state == S_IDLE) & i_start & ~i_flush;

    always_comb begin
        signed_op = 1'b0;
        is_div_op = 1'b0;
        case (i_md_op)
            MD_MULT: signed_op = 1'b1;
            MD_DIV:  begin signed_op = 1'b1; is_div_op = 1'b1; end
            MD_DIVU: is_div_op = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (accept && md_is_iter(i_md_op)) state_nx = S_RUN;
            S_RUN:   if (cnt == '0) state_nx = S_FIXUP;
            S_FIXUP: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        load      = accept & md_is_iter(i_md_op);
        step      = (state == S_RUN);
        write_res = (state == S_FIXUP);
        write_hi  = accept & (i_md_op == MD_MTHI);
        write_lo  = accept & (i_md_op == MD_MTLO);
    end

    ex_muldiv_datapath #(.DATA_WIDTH(W)) u_dp (
        .data_1   (i_data_1),
        .data_2   (i_data_2),
        .signed_op(signed_op),
        .mag_1    (mag_1),
        .mag_2    (mag_2),
        .sign_1   (sign_1),
        .sign_2   (sign_2),
        .acc      (acc),
        .divisor  (divisor),
        .is_div   (div_q),
        .neg_q    (neg_q),
        .neg_r    (neg_r),
        .div_zero (dz_q),
        .rs       (rs),
        .acc_next (acc_next),
        .res_hi   (res_hi),
        .res_lo   (res_lo)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_hi    <= '0;
            o_lo    <= '0;
            cnt     <= '0;
            acc     <= '0;
            divisor <= '0;
            rs      <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            o_busy <= (state_nx != S_IDLE);
            o_done <= write_res;
            if (load) begin
                acc     <= {{W{1'b0}}, mag_1};
                divisor <= mag_2;
                rs      <= i_data_1;
                div_q   <= is_div_op;
                neg_q   <= sign_1 ^ sign_2;
                neg_r   <= sign_1;
                dz_q    <= (i_data_2 == '0);
                cnt     <= CW'(W - 1);
            end else if (step) begin
                acc <= acc_next;
                cnt <= cnt - CW'(1);
            end
            if (write_res) begin
                o_hi <= res_hi;
                o_lo <= res_lo;
            end else begin
                if (write_hi) o_hi <= i_data_1;
                if (write_lo) o_lo <= i_data_1;
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: arithmetic reference model,
// directed corner cases plus randomized mul/div traffic.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_start;
    logic        i_flush;
    logic [2:0]  i_md_op;
    logic [31:0] i_data_1;
    logic [31:0] i_data_2;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_hi;
    logic [31:0] o_lo;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] sb_q[$];
    int          busy_cnt = 0;
    bit          prev_done = 1'b0;
    bit          allow_illegal = 1'b0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    always #5 clk = ~clk;

    ex_muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_start (i_start),
        .i_flush (i_flush),
        .i_md_op (i_md_op),
        .i_data_1(i_data_1),
        .i_data_2(i_data_2),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_hi    (o_hi),
        .o_lo    (o_lo)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, returns {hi, lo}
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q, m;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = '0;
        case (op)
            3'd1: r = sa * sb;
            3'd2: r = {32'b0, a} * {32'b0, b};
            3'd3: begin
                if (b == 0) r = {a, 32'hFFFFFFFF};
                else begin
                    q = sa / sb;
                    m = sa % sb;
                    r = {m[31:0], q[31:0]};
                end
            end
            3'd4: begin
                if (b == 0) r = {a, 32'hFFFFFFFF};
                else r = {a % b, a / b};
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 9))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            busy_cnt  = 0;
            prev_done = 1'b0;
        end else begin
            if (o_busy) busy_cnt++;
            if (o_done) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", {63'b0, o_done}, 64'd0);
                end else begin
                    logic [63:0] e;
                    e = sb_q.pop_front();
                    chk("result_hi", {32'b0, o_hi}, {32'b0, e[63:32]});
                    chk("result_lo", {32'b0, o_lo}, {32'b0, e[31:0]});
                    chk("busy_cycles", 64'(busy_cnt), 64'd33);
                    chk("done_single", {63'b0, prev_done}, 64'd0);
                end
                busy_cnt = 0;
            end
            prev_done = o_done;
        end
    end

    always @(posedge clk) begin
        if (reset && o_busy && i_start && !i_flush && !allow_illegal)
            chk("start_while_busy", {63'b0, i_start}, 64'd0);
    end

    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit inject);
        logic [63:0] e;
        e = model(op, a, b);
        @(negedge clk);
        i_start  = 1'b1;
        i_flush  = 1'b0;
        i_md_op  = op;
        i_data_1 = a;
        i_data_2 = b;
        sb_q.push_back(e);
        @(negedge clk);
        i_start  = 1'b0;
        i_md_op  = 3'd0;
        i_data_1 = $urandom;
        i_data_2 = $urandom;
        chk("busy_rise", {63'b0, o_busy}, 64'd1);
        for (int c = 0; c < 40 && !o_done; c++) begin
            if (c == 5) begin
                chk("hold_hi", {32'b0, o_hi}, {32'b0, exp_hi});
                chk("hold_lo", {32'b0, o_lo}, {32'b0, exp_lo});
            end
            i_start       = inject && (c == 10);
            allow_illegal = i_start;
            if (i_start) begin
                i_md_op  = 3'd5;
                i_data_1 = 32'h0000DEAD;
            end
            @(negedge clk);
        end
        i_start       = 1'b0;
        allow_illegal = 1'b0;
        chk("done_seen", {63'b0, o_done}, 64'd1);
        exp_hi = e[63:32];
        exp_lo = e[31:0];
    endtask

    initial begin
        reset    = 1'b0;
        i_start  = 1'b0;
        i_flush  = 1'b0;
        i_md_op  = 3'd0;
        i_data_1 = '0;
        i_data_2 = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {63'b0, o_busy}, 64'd0);
        chk("rst_done", {63'b0, o_done}, 64'd0);
        chk("rst_hilo", {o_hi, o_lo}, 64'd0);
        reset = 1'b1;

        run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        run_op(3'd1, 32'hFFFFFFFD, 32'd5, 1'b0);
        run_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
        run_op(3'd4, 32'd100, 32'd7, 1'b0);
        run_op(3'd4, 32'h1234, 32'd0, 1'b0);
        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);

        // MTHI then MTLO back to back
        @(negedge clk);
        i_start  = 1'b1;
        i_md_op  = 3'd5;
        i_data_1 = 32'h0000AAAA;
        @(negedge clk);
        chk("mthi_hi", {32'b0, o_hi}, 64'h0000AAAA);
        chk("mthi_busy", {63'b0, o_busy}, 64'd0);
        i_md_op  = 3'd6;
        i_data_1 = 32'h00005555;
        @(negedge clk);
        i_start = 1'b0;
        chk("mtlo_lo", {32'b0, o_lo}, 64'h00005555);
        chk("mtlo_hi", {32'b0, o_hi}, 64'h0000AAAA);
        chk("mtlo_busy", {63'b0, o_busy}, 64'd0);
        exp_hi = 32'h0000AAAA;
        exp_lo = 32'h00005555;

        // flushed start must be a no-op
        @(negedge clk);
        i_start  = 1'b1;
        i_flush  = 1'b1;
        i_md_op  = 3'd1;
        i_data_1 = 32'd2;
        i_data_2 = 32'd3;
        @(negedge clk);
        i_start = 1'b0;
        i_flush = 1'b0;
        repeat (3) @(negedge clk);
        chk("flush_busy", {63'b0, o_busy}, 64'd0);
        chk("flush_hilo", {o_hi, o_lo}, {exp_hi, exp_lo});

        run_op(3'd1, 32'h00001234, 32'hFFFF5678, 1'b1);

        for (int n = 0; n < 30; n++)
            run_op(3'($urandom_range(1, 4)), pick(), pick(), 1'b0);

        // asynchronous reset in the middle of a multiply
        @(negedge clk);
        i_start  = 1'b1;
        i_md_op  = 3'd2;
        i_data_1 = 32'h12345678;
        i_data_2 = 32'd9;
        @(negedge clk);
        i_start = 1'b0;
        repeat (10) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("areset_busy", {63'b0, o_busy}, 64'd0);
        chk("areset_hilo", {o_hi, o_lo}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset  = 1'b1;
        exp_hi = '0;
        exp_lo = '0;
        run_op(3'd2, 32'd6, 32'd7, 1'b0);
        chk("post_reset_mul", {o_hi, o_lo}, 64'd42);

        repeat (3) @(negedge clk);
        chk("queue_empty", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
EX-stage iterative multiply/divide engine. It consumes the operands and control that the ID/EX pipeline register presents to the EX stage. It owns the HI/LO architectural registers and computes MULT/MULTU/DIV/DIVU over multiple cycles. It raises a busy/stall indication back to the hazard unit so later instructions are held in ID and the ID/EX register is flushed until the operation completes.

Parameters:
DATA_WIDTH, 32, operand/HI/LO width; iteration count equals DATA_WIDTH.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
i_start  in  1  EX-stage instruction is a mul/div/mthi/mtlo op
i_flush  in  1  EX instruction is squashed; qualifies i_start
i_md_op  in  3  000 NONE, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO; others treated as NONE
i_data_1  in  DATA_WIDTH  rs operand (forwarded value)
i_data_2  in  DATA_WIDTH  rt operand (forwarded value)
o_busy  out  1  registered; engine iterating; hazard unit stalls on mfhi/mflo/any md op
o_done  out  1  one-cycle pulse when a mul/div result lands in HI/LO
o_hi  out  DATA_WIDTH  HI register
o_lo  out  DATA_WIDTH  LO register

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, o_hi=0, o_lo=0, o_busy=0, o_done=0, counter=0, all datapath registers 0. Reset mid-operation aborts the operation with no HI/LO write.
- Accept: at an edge with state IDLE, i_start=1, and i_flush=0. With i_flush=1, i_start is ignored entirely.
- MTHI/MTLO: on the accept edge o_hi<=i_data_1 (MTHI) or o_lo<=i_data_1 (MTLO). State stays IDLE; no busy, no done.
- MULT/MULTU/DIV/DIVU: on the accept edge:
  - latch operand magnitudes (absolute values for signed ops),
  - latch result-sign flags (quotient sign = sign1 XOR sign2; remainder sign = sign1),
  - latch the original rs,
  - load counter=DATA_WIDTH-1,
  - go to RUN; o_busy=1 from the next cycle.
- States: IDLE -> RUN -> FIXUP -> IDLE.
  - RUN: one iteration per cycle for DATA_WIDTH cycles; leave when counter==0 at an edge.
  - Multiply: shift-add into a 2*DATA_WIDTH product.
  - Divide: restoring, one quotient bit per cycle; partial remainder is DATA_WIDTH+1 bits.
  - FIXUP (1 cycle): apply two's-complement negation per the sign flags, then write HI/LO on the exiting edge.
- Latency: accept at edge 0; HI/LO written at edge DATA_WIDTH+1 (33). o_busy=1 for exactly DATA_WIDTH+1 cycles; it drops at the same edge where HI/LO update and o_done pulses high for one cycle.
- Results:
  - MULT/MULTU: {o_hi,o_lo} = full 64-bit product.
  - DIV/DIVU: o_lo = quotient, o_hi = remainder. Remainder carries the dividend's sign; quotient truncates toward zero.
- Divide by zero (i_data_2==0, any signedness): runs the full latency; result o_lo=all ones, o_hi=original i_data_1; sign fixup is suppressed.
- Signed overflow (-2^31 / -1): o_lo=32'h80000000, o_hi=0. No exception.
- i_start while o_busy=1: ignored, and HI/LO are not disturbed. The hazard unit is required to prevent this; the bench asserts it never occurs.
- i_flush asserted during RUN/FIXUP does not abort; the accepted instruction has already left ID/EX.
- o_hi/o_lo hold their previous values throughout RUN/FIXUP.

Decomposition:
- Shared package: md_op encoding constants (MD_NONE..MD_MTLO) and the state encoding (IDLE/RUN/FIXUP), reused by the control unit and the hazard unit.
- One sub-module is natural: ex_muldiv_datapath (shift-add/restoring step logic plus sign fixup). The top module holds the FSM, counter, and HI/LO registers.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> after edge 33: o_hi=0xFFFFFFFE, o_lo=0x00000001; o_busy high exactly 33 cycles; o_done single pulse.
- MULT -3*5 -> o_hi=0xFFFFFFFF, o_lo=0xFFFFFFF1. DIV -7/2 -> o_lo=0xFFFFFFFD, o_hi=0xFFFFFFFF. DIVU 100/7 -> o_lo=14, o_hi=2.
- DIVU 0x1234/0 -> o_lo=0xFFFFFFFF, o_hi=0x1234. DIV 0x80000000/0xFFFFFFFF -> o_lo=0x80000000, o_hi=0.
- MTHI 0xAAAA then MTLO 0x5555 on consecutive cycles -> o_hi=0xAAAA, o_lo=0x5555 after the next edges; o_busy never rises.
- i_start=1 with i_flush=1 (MULT 2*3) -> no state change, HI/LO unchanged. i_start pulsed during RUN -> ignored, and the original result is correct.
- reset pulled low at RUN cycle 10 -> o_busy=0 and HI/LO=0 immediately (asynchronous); after release a new MULTU 6*7 gives o_lo=42, o_hi=0.
